key_dispatch_scheduler: RTL
===========================

Name: key_dispatch_scheduler

Overview:
Sequences a bank of NUM_CORES RC4 decryption cores through a brute-force key search. It hands out ascending secret keys from a shared key counter, restarts each core per key with a reset/new-key handshake, and collects each core's done and result-valid verdict. It halts every core on the first valid key, or reports exhaustion once the key space is spent. It sits between the top-level control (start, LEDs/HEX) and the replicated decryption cores.

Parameters:
NUM_CORES, 4, number of decryption cores scheduled (1..16)
KEY_WIDTH, 24, secret key width in bits
KEY_MAX, 24'h3FFFFF, last key value searched (inclusive)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a search at key 0
core_done  in  NUM_CORES  per-core done flag; level, held until the core is reset
core_key_valid  in  NUM_CORES  per-core verdict from the result checker; sampled only in a cycle where core_done[c]=1
core_reset  out  NUM_CORES  per-core restart pulse (drives the core's reset input)
core_new_key_available  out  NUM_CORES  per-core key-start pulse
core_key  out  NUM_CORES*KEY_WIDTH  per-core secret key; slice c = bits [c*KEY_WIDTH +: KEY_WIDTH]
core_stop  out  1  stop to all cores; held high in FOUND
busy  out  1  high in RUN
found  out  1  high in FOUND
exhausted  out  1  high in EXHAUSTED
found_key  out  KEY_WIDTH  key that produced the valid result
keys_issued  out  KEY_WIDTH+1  count of keys launched since start

Behaviour:
- Reset (synchronous, active-high): all outputs 0, global state IDLE, every core slot IDLE, next_key=0, rr_ptr=0. Applies mid-search too: the search is abandoned with no result retained.
- Global FSM: IDLE -> RUN on start. RUN -> FOUND on the first valid verdict. RUN -> EXHAUSTED when next_key > KEY_MAX and every slot is IDLE. From FOUND or EXHAUSTED, start -> RUN, clearing found, exhausted, found_key, keys_issued and next_key. start in RUN is ignored.
- Per-core slot FSM:
  - IDLE -> LAUNCH when the slot is granted.
  - LAUNCH: exactly 1 cycle; core_reset[c]=1.
  - ARM: exactly 1 cycle; core_new_key_available[c]=1.
  - BUSY: wait for core_done[c].
  - On core_done[c]=1 in BUSY: the slot returns to IDLE next cycle.
- Grant (RUN only; next_key <= KEY_MAX): at most one slot granted per cycle. Round-robin among IDLE slots starting at rr_ptr; rr_ptr advances to grant+1 (mod NUM_CORES).
- In the grant cycle: core_key slice c <= next_key, next_key++, keys_issued++. The slice stays stable until that slot's next grant.
- Launch latency: grant in cycle t -> core_reset[c] at t+1 -> core_new_key_available[c] at t+2.
- Verdict: core_done[c]=1 with core_key_valid[c]=1 in BUSY -> found=1 and found_key = core_key slice c, both registered next cycle; core_stop=1 from the same cycle.
  - Several valid verdicts in the same cycle: lowest index wins.
  - Once FOUND: no new grants, later verdicts ignored, in-flight slots drop to IDLE.
- core_done[c] outside BUSY is ignored.
- next_key is KEY_WIDTH+1 bits, so it does not wrap at KEY_MAX=all-ones.
- keys_issued saturates at all-ones.
- A core that never asserts done stalls only its own slot; no timeout.
- Output pulses and state outputs are registered; no combinational path from inputs to outputs except core_stop.

Test Plan:
- NUM_CORES=4, KEY_MAX=7, no valid verdicts, each core asserts done 20 cycles after its new_key pulse -> keys 0,1,2,3 granted to cores 0..3 on consecutive cycles. keys_issued ends at 8, exhausted=1 one cycle after the last slot goes IDLE, found=0.
- Same setup, core_key_valid asserted for key 5 -> found=1, found_key=5, core_stop=1. No grant for key 8 ever occurs, exhausted stays 0.
- Cores 1 and 3 finish valid in the same cycle with keys 5 and 7 -> found_key=5 (core 1 wins).
- Grant 0 in cycle t -> core_reset[0]=1 only in t+1 and core_new_key_available[0]=1 only in t+2, single-cycle each. core_key[0] is unchanged while BUSY.
- Reset asserted mid-RUN, then start -> all outputs 0 the cycle after reset; the first grant after start carries key 0 to core 0.
- start during RUN -> ignored, next_key continues. start after FOUND -> found cleared and the search restarts at key 0.

Source files
------------

// File: rtl/key_dispatch_scheduler.sv
// Brute-force key dispatcher for a bank of RC4 decryption cores.
// Hands ascending keys to idle cores round-robin, restarts each core with a
// reset / new-key handshake, and stops everything on the first valid verdict.
module key_dispatch_scheduler #(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_key_valid,
    output logic [NUM_CORES-1:0]           core_reset,
    output logic [NUM_CORES-1:0]           core_new_key_available,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic                           core_stop,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [KEY_WIDTH:0]             keys_issued
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [1:0] G_IDLE  = 2'd0;
    localparam logic [1:0] G_RUN   = 2'd1;
    localparam logic [1:0] G_FOUND = 2'd2;
    localparam logic [1:0] G_EXH   = 2'd3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_ARM    = 2'd2;
    localparam logic [1:0] S_BUSY   = 2'd3;

    // One extra bit so the counter can step past an all-ones KEY_MAX.
    localparam logic [KEY_WIDTH:0] KEY_LIMIT = {1'b0, KEY_MAX};

    logic [1:0]           gstate_q, gstate_d;
    logic [1:0]           slot_q [NUM_CORES];
    logic [1:0]           slot_d [NUM_CORES];
    logic [KEY_WIDTH-1:0] key_q  [NUM_CORES];
    logic [KEY_WIDTH:0]   next_key_q, next_key_d;
    logic [KEY_WIDTH:0]   keys_issued_q, keys_issued_d;
    logic [KEY_WIDTH-1:0] found_key_q, found_key_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic                 hit_valid;
    logic [PTR_W-1:0]     hit_idx;
    logic                 all_idle;
    int                   idx_int;

    // Lowest-index core reporting done+valid while BUSY in RUN.
    always_comb begin
        hit_valid = 1'b0;
        hit_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (slot_q[i] == S_BUSY && core_done[i] && core_key_valid[i]) begin
                hit_valid = 1'b1;
                hit_idx   = i[PTR_W-1:0];
            end
        end
        if (gstate_q != G_RUN) begin
            hit_valid = 1'b0;
        end
    end

    // Round-robin pick of the first idle slot at or after rr_ptr; no grant in a verdict cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx_int     = 0;
        all_idle    = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (slot_q[i] != S_IDLE) begin
                all_idle = 1'b0;
            end
            idx_int = int'(rr_ptr_q) + i;
            if (idx_int >= NUM_CORES) begin
                idx_int = idx_int - NUM_CORES;
            end
            if (!grant_valid && slot_q[idx_int[PTR_W-1:0]] == S_IDLE) begin
                grant_valid = 1'b1;
                grant_idx   = idx_int[PTR_W-1:0];
            end
        end
        if (gstate_q != G_RUN || next_key_q > KEY_LIMIT || hit_valid) begin
            grant_valid = 1'b0;
        end
    end

    // Global search FSM plus key counter, issue counter and result capture.
    always_comb begin
        gstate_d      = gstate_q;
        next_key_d    = next_key_q;
        keys_issued_d = keys_issued_q;
        found_key_d   = found_key_q;
        rr_ptr_d      = rr_ptr_q;
        case (gstate_q)
            G_RUN: begin
                if (hit_valid) begin
                    gstate_d    = G_FOUND;
                    found_key_d = key_q[hit_idx];
                end else if (next_key_q > KEY_LIMIT && all_idle) begin
                    gstate_d = G_EXH;
                end
            end
            default: begin
                if (start) begin
                    gstate_d      = G_RUN;
                    next_key_d    = '0;
                    keys_issued_d = '0;
                    found_key_d   = '0;
                end
            end
        endcase
        if (grant_valid) begin
            next_key_d = next_key_q + 1'b1;
            if (keys_issued_q != '1) begin
                keys_issued_d = keys_issued_q + 1'b1;
            end
            if (grant_idx == PTR_W'(NUM_CORES - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Per-slot launch sequence; anything outside RUN parks every slot in IDLE.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                S_IDLE: begin
                    if (grant_valid && grant_idx == i[PTR_W-1:0]) begin
                        slot_d[i] = S_LAUNCH;
                    end
                end
                S_LAUNCH: slot_d[i] = S_ARM;
                S_ARM:    slot_d[i] = S_BUSY;
                default: begin
                    if (core_done[i]) begin
                        slot_d[i] = S_IDLE;
                    end
                end
            endcase
            if (gstate_q != G_RUN) begin
                slot_d[i] = S_IDLE;
            end
        end
    end

    // State registers; the granted slot latches the current key.
    always_ff @(posedge clk) begin
        if (reset) begin
            gstate_q      <= G_IDLE;
            next_key_q    <= '0;
            keys_issued_q <= '0;
            found_key_q   <= '0;
            rr_ptr_q      <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_q[i] <= S_IDLE;
                key_q[i]  <= '0;
            end
        end else begin
            gstate_q      <= gstate_d;
            next_key_q    <= next_key_d;
            keys_issued_q <= keys_issued_d;
            found_key_q   <= found_key_d;
            rr_ptr_q      <= rr_ptr_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_q[i] <= slot_d[i];
            end
            if (grant_valid) begin
                key_q[grant_idx] <= next_key_q[KEY_WIDTH-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core_out
            assign core_reset[gi]             = (slot_q[gi] == S_LAUNCH);
            assign core_new_key_available[gi] = (slot_q[gi] == S_ARM);
            assign core_key[gi*KEY_WIDTH +: KEY_WIDTH] = key_q[gi];
        end
    endgenerate

    // core_stop rises in the verdict cycle itself so cores halt without waiting a clock.
    assign core_stop   = (gstate_q == G_FOUND) || hit_valid;
    assign busy        = (gstate_q == G_RUN);
    assign found       = (gstate_q == G_FOUND);
    assign exhausted   = (gstate_q == G_EXH);
    assign found_key   = found_key_q;
    assign keys_issued = keys_issued_q;

endmodule
